// File: rtl/snake_dir_queue_fsm_if.sv
// snake_dir_queue_fsm_if: keypad/collision/control bundle between the game controller (master) and the direction FSM (slave).
interface snake_dir_queue_fsm_if #(parameter int NUM_PLAYERS = 2);
   logic [NUM_PLAYERS-1:0] key_valid, X, drop, q_full;
   logic [2*NUM_PLAYERS-1:0] key_dir;
   logic [3*NUM_PLAYERS-1:0] state;
   logic pause_req, restart, move_tick, paused, all_over;
   modport master (output key_valid, key_dir, X, pause_req, restart,
                   input state, move_tick, paused, drop, q_full, all_over);
   modport slave (input key_valid, key_dir, X, pause_req, restart,
                  output state, move_tick, paused, drop, q_full, all_over);
endinterface

// File: rtl/snake_dir_queue_fsm.sv
// snake_dir_queue_fsm: multi-player snake direction FSM with per-player key queues, pause, game-over and restart.
// Define SNAKE_REVERSAL_BLOCK_EN to reject 180-degree reversals of the newest accepted direction.
module snake_dir_queue_fsm #(
   parameter int NUM_PLAYERS = 2,
   parameter int QDEPTH = 2,
   parameter int TICK_DIV = 4
) (
   input logic clkFSM,
   input logic reset,
   snake_dir_queue_fsm_if.slave bus
);
   localparam int AW = $clog2(QDEPTH);
   localparam int NW = AW + 1;
   localparam int CW = $clog2(TICK_DIV);
   typedef enum logic [2:0] {START, UP, DOWN, LEFT, RIGHT, OVER} dir_t;

   function automatic dir_t to_dir(logic [1:0] d);
      return dir_t'({1'b0, d} + 3'd1);
   endfunction

   dir_t st [NUM_PLAYERS];
   dir_t last [NUM_PLAYERS];
   dir_t req [NUM_PLAYERS];
   logic [1:0] q [NUM_PLAYERS][QDEPTH];
   logic [AW-1:0] rp [NUM_PLAYERS];
   logic [AW-1:0] wp [NUM_PLAYERS];
   logic [NW-1:0] cnt [NUM_PLAYERS];
   logic [CW-1:0] tcnt;
   logic move_tick_r, paused_r, pause_d;
   logic [NUM_PLAYERS-1:0] drop_r, pop, push, rej, rev, over, full;
   logic rise, run, tick_end, restart_ok;

   // run is low in the pause-toggling cycle too, so move_tick is never high while paused
   assign rise = bus.pause_req & ~pause_d;
   assign run = ~paused_r & ~rise;
   assign tick_end = tcnt == CW'(TICK_DIV - 1);
   assign restart_ok = bus.restart & bus.all_over;
   assign bus.move_tick = move_tick_r;
   assign bus.paused = paused_r;
   assign bus.drop = drop_r;

   always_comb begin
      bus.state = '0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         req[i] = to_dir(bus.key_dir[2*i +: 2]);
         over[i] = st[i] == OVER;
         full[i] = cnt[i] == NW'(QDEPTH);
         pop[i] = move_tick_r & ~paused_r & (cnt[i] != '0);
`ifdef SNAKE_REVERSAL_BLOCK_EN
         rev[i] = last[i] != START && last[i] != OVER && bus.key_dir[2*i +: 2] == (2'(last[i] - 3'd1) ^ 2'd1);
`else
         rev[i] = 1'b0;
`endif
         rej[i] = paused_r | bus.X[i] | last[i] == OVER | req[i] == last[i] |
                  (last[i] == START && req[i] == LEFT) | rev[i] | (full[i] & ~pop[i]);
         push[i] = bus.key_valid[i] & ~rej[i];
         bus.state[3*i +: 3] = st[i];
      end
      bus.q_full = full;
      bus.all_over = &over;
   end

   always_ff @(posedge clkFSM or negedge reset) begin
      if (!reset) begin
         tcnt <= '0;
         move_tick_r <= 1'b0;
         paused_r <= 1'b0;
         pause_d <= 1'b0;
         drop_r <= '0;
         for (int i = 0; i < NUM_PLAYERS; i++) begin
            st[i] <= START;
            last[i] <= START;
            rp[i] <= '0;
            wp[i] <= '0;
            cnt[i] <= '0;
            for (int j = 0; j < QDEPTH; j++) q[i][j] <= '0;
         end
      end else begin
         pause_d <= bus.pause_req;
         paused_r <= paused_r ^ rise;
         drop_r <= bus.key_valid & rej;
         tcnt <= restart_ok ? '0 : run ? (tick_end ? '0 : tcnt + CW'(1)) : tcnt;
         move_tick_r <= ~restart_ok & run & tick_end;
         for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (restart_ok || bus.X[i]) begin
               st[i] <= restart_ok ? START : OVER;
               last[i] <= restart_ok ? START : OVER;
               rp[i] <= '0;
               wp[i] <= '0;
               cnt[i] <= '0;
            end else begin
               if (pop[i]) begin
                  st[i] <= to_dir(q[i][rp[i]]);
                  rp[i] <= rp[i] + AW'(1);
               end
               if (push[i]) begin
                  q[i][wp[i]] <= bus.key_dir[2*i +: 2];
                  wp[i] <= wp[i] + AW'(1);
                  last[i] <= req[i];
               end
               cnt[i] <= cnt[i] + NW'(push[i]) - NW'(pop[i]);
            end
         end
      end
   end
endmodule

// File: tb/tb_snake_dir_queue_fsm.sv
// tb_snake_dir_queue_fsm: directed bench for snake_dir_queue_fsm with NUM_PLAYERS=2, QDEPTH=2, TICK_DIV=4.
module tb_snake_dir_queue_fsm;
   logic clkFSM = 1'b0;
   logic reset = 1'b1;
   int total = 0;
   int passed = 0;
   int n;
`ifdef SNAKE_REVERSAL_BLOCK_EN
   localparam logic [2:0] P1 = 3'd1;
   localparam logic [1:0] P1_DROP = 2'b10;
`else
   localparam logic [2:0] P1 = 3'd2;
   localparam logic [1:0] P1_DROP = 2'b00;
`endif

   snake_dir_queue_fsm_if #(.NUM_PLAYERS(2)) bus ();
   snake_dir_queue_fsm #(.NUM_PLAYERS(2), .QDEPTH(2), .TICK_DIV(4)) dut (
      .clkFSM(clkFSM),
      .reset(reset),
      .bus(bus.slave)
   );

   always #5 clkFSM = ~clkFSM;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic cyc();
      @(posedge clkFSM);
      #1;
   endtask

   task automatic press(input int p, input logic [1:0] d);
      bus.key_valid[p] = 1'b1;
      bus.key_dir[2*p +: 2] = d;
      cyc();
      bus.key_valid = '0;
   endtask

   // waits for the current or next move_tick cycle, then steps past the edge that pops
   task automatic wait_tick();
      int k = 0;
      while (!bus.move_tick && k < 8) begin
         cyc();
         k++;
      end
      chk("tick_seen", bus.move_tick, 1);
      cyc();
   endtask

   initial begin
      bus.key_valid = '0;
      bus.key_dir = '0;
      bus.X = '0;
      bus.pause_req = 1'b0;
      bus.restart = 1'b0;
      #2 reset = 1'b0;
      #1;
      chk("rst_state", bus.state, 0);
      chk("rst_q_full", bus.q_full, 0);
      chk("rst_move_tick", bus.move_tick, 0);
      chk("rst_paused", bus.paused, 0);
      chk("rst_drop", bus.drop, 0);
      chk("rst_all_over", bus.all_over, 0);
      #19 reset = 1'b1;

      press(0, 2'd2);
      chk("s1_left_drop", bus.drop, 2'b01);
      press(0, 2'd0);
      chk("s1_up_nodrop", bus.drop, 2'b00);
      chk("s1_state_hold", bus.state, 0);
      wait_tick();
      chk("s1_state_up", bus.state, 6'o01);

      press(0, 2'd3);
      wait_tick();
      chk("s2_state_right", bus.state, 6'o04);
      press(0, 2'd0);
      chk("s2_up_q_full", bus.q_full, 2'b00);
      chk("s2_up_drop", bus.drop, 2'b00);
      press(0, 2'd2);
      chk("s2_left_q_full", bus.q_full, 2'b01);
      press(0, 2'd1);
      chk("s2_down_drop", bus.drop, 2'b01);
      chk("s2_down_q_full", bus.q_full, 2'b01);
      chk("s2_tick_now", bus.move_tick, 1);
      wait_tick();
      chk("s2_state_up", bus.state, 6'o01);
      chk("s2_q_after_pop", bus.q_full, 2'b00);
      wait_tick();
      chk("s2_state_left", bus.state, 6'o03);

      press(1, 2'd0);
      wait_tick();
      chk("s3_p1_up", bus.state, 6'o13);
      press(1, 2'd1);
      chk("s3_rev_drop", bus.drop, P1_DROP);
      wait_tick();
      chk("s3_p1_after_rev", bus.state, {P1, 3'd3});

      press(0, 2'd0);
      press(0, 2'd3);
      chk("s4_full", bus.q_full, 2'b01);
      cyc();
      chk("s4_tick", bus.move_tick, 1);
      press(0, 2'd1);
      chk("s4_push_pop_drop", bus.drop, 2'b00);
      chk("s4_push_pop_full", bus.q_full, 2'b01);
      chk("s4_push_pop_state", bus.state, {P1, 3'd1});

      bus.pause_req = 1'b1;
      cyc();
      bus.pause_req = 1'b0;
      chk("s5_paused", bus.paused, 1);
      press(1, 2'd2);
      chk("s5_paused_drop", bus.drop, 2'b10);
      chk("s5_paused_no_tick", bus.move_tick, 0);
      bus.X = 2'b01;
      cyc();
      bus.X = 2'b00;
      chk("s5_x0_state", bus.state, {P1, 3'd5});
      chk("s5_x0_flush", bus.q_full, 2'b00);
      press(0, 2'd0);
      chk("s5_over_drop", bus.drop, 2'b01);
      bus.restart = 1'b1;
      cyc();
      bus.restart = 1'b0;
      chk("s5_restart_ignored", bus.state, {P1, 3'd5});
      chk("s5_not_all_over", bus.all_over, 0);
      bus.X = 2'b10;
      cyc();
      bus.X = 2'b00;
      chk("s5_all_over", bus.all_over, 1);
      chk("s5_both_over", bus.state, 6'o55);
      bus.restart = 1'b1;
      cyc();
      bus.restart = 1'b0;
      chk("s5_restart_state", bus.state, 0);
      chk("s5_restart_all_over", bus.all_over, 0);
      chk("s5_restart_keeps_pause", bus.paused, 1);

      bus.pause_req = 1'b1;
      cyc();
      bus.pause_req = 1'b0;
      chk("s6_unpaused", bus.paused, 0);
      cyc();
      cyc();
      bus.pause_req = 1'b1;
      cyc();
      bus.pause_req = 1'b0;
      chk("s6_paused_again", bus.paused, 1);
      n = 0;
      repeat (20) begin
         cyc();
         n += int'(bus.move_tick);
      end
      chk("s6_no_tick_paused", n, 0);
      bus.pause_req = 1'b1;
      cyc();
      bus.pause_req = 1'b0;
      cyc();
      chk("s6_resume_early", bus.move_tick, 0);
      cyc();
      chk("s6_resume_tick", bus.move_tick, 1);
      n = 0;
      repeat (3) begin
         cyc();
         n += int'(bus.move_tick);
      end
      chk("s6_period_gap", n, 0);
      cyc();
      chk("s6_period_tick", bus.move_tick, 1);

      bus.key_valid = 2'b11;
      bus.key_dir = 4'b0000;
      cyc();
      bus.key_valid = '0;
      press(0, 2'd3);
      chk("s7_full_before_rst", bus.q_full, 2'b01);
      #2 reset = 1'b0;
      #1;
      chk("s7_rst_state", bus.state, 0);
      chk("s7_rst_q_full", bus.q_full, 0);
      chk("s7_rst_move_tick", bus.move_tick, 0);
      chk("s7_rst_drop", bus.drop, 0);
      #2 reset = 1'b1;
      press(0, 2'd0);
      wait_tick();
      chk("s7_resume_state", bus.state, 6'o01);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/snake_dir_queue_fsm.md
# snake_dir_queue_fsm

Parametrised multi-player successor of the snake direction FSM. Each player has a small key-request queue, so quick key sequences between move ticks are kept rather than lost. A queued request is applied only on an internally generated move tick. The block adds global pause, sticky per-player game-over with a restart, and drop reporting. It sits between the keypad decoders and the snake position/collision logic and drives one direction state per player.

## Interface
- NUM_PLAYERS, 2, number of independent snakes (1..4)
- QDEPTH, 2, request queue depth per player (power of two, 2..8)
- TICK_DIV, 4, clkFSM cycles per move tick (2..2^16)

- clkFSM  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; low forces the reset state immediately
- key_valid  in  NUM_PLAYERS  one-cycle request strobe per player
- key_dir  in  2*NUM_PLAYERS  per-player request code: 0 Up, 1 Down, 2 Left, 3 Right; player i uses bits [2i+1:2i]
- X  in  NUM_PLAYERS  per-player collision level from position logic
- pause_req  in  1  pause toggle; rising edge detected internally
- restart  in  1  one-cycle strobe, honoured only while all_over=1
- state  out  3*NUM_PLAYERS  per-player state: 0 start, 1 Up, 2 Down, 3 Left, 4 Right, 5 Over; player i uses bits [3i+2:3i]
- move_tick  out  1  one-cycle pulse at each move boundary
- paused  out  1  pause flag
- drop  out  NUM_PLAYERS  one-cycle pulse when a request is rejected
- q_full  out  NUM_PLAYERS  queue count == QDEPTH
- all_over  out  1  every player in Over

## Operation
- Per player, a last_dir register tracks the newest accepted direction. If the queue is empty, last_dir equals state.
- Request filter, applied in the cycle key_valid is high. The request is rejected (drop=1) if any of these holds:
  - paused=1
  - player is in Over
  - request equals last_dir
  - last_dir=start and request=Left
  - request reverses last_dir (Up/Down, Left/Right), with SNAKE_REVERSAL_BLOCK_EN only
  - queue is full and no pop happens in the same cycle
- An accepted request is pushed at the queue tail, and last_dir takes the request value.
- On move_tick with paused=0, every player whose queue is non-empty pops the head into state. A player with an empty queue holds its state.
- Same-cycle push and pop on a full queue: both take effect; count is unchanged and the request is accepted.
- Collision: X[i]=1 on any edge (including while paused) forces state=Over on the next edge. The same edge flushes the queue and sets last_dir=Over. X has priority over pop and push.
- Over is sticky. With all_over=1, a restart strobe returns every player to start on the next edge, flushes all queues, and clears the tick counter. restart is ignored otherwise.
- Pause: each pause_req rising edge toggles paused. While paused, the tick counter freezes and move_tick stays 0.

## Timing
- Reset values:
  - state = 0 for all players
  - last_dir = start
  - queues empty, q_full = 0, drop = 0
  - tick counter = 0, move_tick = 0
  - paused = 0, pause edge detector = 0
  - all_over = 0
- Tick counter counts 0..TICK_DIV-1. move_tick is registered and is high in the cycle after the counter reaches TICK_DIV-1. Period is exactly TICK_DIV cycles.
- Request latency:
  - The request is registered into the queue at the first edge after key_valid.
  - It appears on state at the edge ending the first move_tick cycle after that.
  - If it lands at the queue head, worst-case latency is TICK_DIV+1 cycles.
- drop is registered, high in the cycle after the rejected key_valid.
- all_over, q_full and state change on the same edge as the underlying event.
- Reset asserted mid-operation: outputs take reset values asynchronously. Operation resumes on the first edge after reset deasserts.

## Configuration
- SNAKE_REVERSAL_BLOCK_EN defined: a 180-degree reversal of last_dir is rejected with a drop pulse.
- SNAKE_REVERSAL_BLOCK_EN undefined: reversals are accepted and queued; upstream collision logic handles self-hits. All other filter rules are unchanged.

## Test plan
All scenarios use NUM_PLAYERS=2, QDEPTH=2, TICK_DIV=4, with SNAKE_REVERSAL_BLOCK_EN defined unless noted.
- Player 0 in start; Left then Up strobed in consecutive cycles -> Left gives drop[0]; Up is queued; state[0]=1 after the next move_tick.
- Player 0 in Right; Up, Left, Down strobed before a tick:
  - Up and Left are accepted, q_full[0]=1.
  - Down is dropped.
  - state[0] becomes 1 on the next tick and 3 on the tick after.
- Player 1 in Up; Down strobed -> drop[1]=1 and state stays 1. With the macro undefined -> state becomes 2 on the next tick.
- X[0] pulsed while paused=1 with two queued entries -> state[0]=5 next edge, queue empty, player 1 unaffected. Then X[1] -> all_over=1; restart -> both states 0.
- pause_req pulses at cycles 10 and 30 -> no move_tick during cycles 11..30; the counter resumes from its frozen value.
- reset driven low mid-tick with queued entries -> all state=0, q_full=0, move_tick=0 with no clock edge.
